// File: rtl/serializer_8_1_bit_if.sv
// ----------------------------------------------------------------------------
// serializer_8_1_bit_if
//
// Purpose:
//   Bundles the parallel input channel and the serial output channel of
//   serializer_8_1_bit. Clock and reset stay plain module ports.
//
// Signals:
//   in_word   [7:0]  parallel word offered to the serializer
//   in_valid         in_word is valid
//   in_ready         serializer can accept in_word this cycle
//   out_bit          current serial bit
//   out_valid        out_bit is valid
//   out_ready        consumer accepts out_bit this cycle
//   out_last         out_bit is the final bit (index 7) of its word
//   bit_index [2:0]  index of the beat being presented (mux select)
//
// Modports:
//   master  surrounding logic: drives in_word/in_valid and out_ready
//   slave   the serializer: drives in_ready and the serial outputs
// ----------------------------------------------------------------------------
interface serializer_8_1_bit_if;
    logic [7:0] in_word;
    logic       in_valid;
    logic       in_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [2:0] bit_index;

    modport master (
        output in_word, in_valid, out_ready,
        input  in_ready, out_bit, out_valid, out_last, bit_index
    );

    modport slave (
        input  in_word, in_valid, out_ready,
        output in_ready, out_bit, out_valid, out_last, bit_index
    );
endinterface

// File: rtl/serializer_8_1_bit.sv
// ----------------------------------------------------------------------------
// serializer_8_1_bit
//
// Purpose:
//   Parallel-to-serial stage. Captures an 8-bit word over a valid/ready
//   handshake, then presents it one bit per accepted output beat. The beat
//   index doubles as the 3-bit select of an 8:1 one-bit mux. A new word can
//   be taken on the final beat of the current one, so back-to-back words
//   stream at 1 bit/cycle with no bubble.
//
// Parameters:
//   IDLE_OUT  value driven on out_bit while out_valid is 0
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    serializer_8_1_bit_if.slave (input word channel, serial output)
//
// Build option:
//   SERIALIZER_MSB_FIRST_EN  when defined, hold[7] is emitted first and
//                            hold[0] last; otherwise LSB first. bit_index,
//                            out_last and the handshakes are unchanged.
// ----------------------------------------------------------------------------
module serializer_8_1_bit #(
    parameter logic IDLE_OUT = 1'b0
) (
    input logic                  clock,
    input logic                  reset,
    serializer_8_1_bit_if.slave  bus
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t     state;
    logic [7:0] hold;
    logic [2:0] bit_index_q;
    logic [2:0] sel;
    logic       at_last;
    logic       accept;
    logic       beat;
    logic       out_bit_c;

    // ------------------------------------------------------------------
    // Output and handshake decode (all from registered state)
    // ------------------------------------------------------------------
    assign at_last = (bit_index_q == 3'd7);

    assign bus.out_valid = (state == SHIFT);
    assign bus.out_last  = (state == SHIFT) && at_last;
    assign bus.bit_index = bit_index_q;

    // Reload is only allowed on the final beat of a word, so hold is never
    // overwritten while bits of it are still pending. Reset blocks intake
    // combinationally so nothing is captured during the reset cycle.
    assign bus.in_ready = !reset &&
                          ((state == IDLE) ||
                           ((state == SHIFT) && at_last && bus.out_ready));

    assign accept = bus.in_valid && bus.in_ready;
    assign beat   = bus.out_valid && bus.out_ready;

`ifdef SERIALIZER_MSB_FIRST_EN
    assign sel = 3'd7 - bit_index_q;
`else
    assign sel = bit_index_q;
`endif

    // 8:1 select straight from the hold register: no added latency.
    // NOTE: every variable written in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        out_bit_c = IDLE_OUT;
        if (state == SHIFT) begin
            out_bit_c = hold[sel];
        end
    end

    assign bus.out_bit = out_bit_c;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    // NOTE: hold is a single data register (not a memory array), so it is
    // cleared on reset along with the control state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            hold        <= 8'h00;
            bit_index_q <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold        <= bus.in_word;
                        bit_index_q <= 3'd0;
                        state       <= SHIFT;
                    end
                end

                SHIFT: begin
                    // Without a beat (out_ready=0) everything holds, which
                    // keeps out_bit/out_last/out_valid stable while stalled.
                    if (beat) begin
                        if (!at_last) begin
                            bit_index_q <= bit_index_q + 3'd1;
                        end else if (accept) begin
                            // Final beat overlaps the next load: no gap.
                            hold        <= bus.in_word;
                            bit_index_q <= 3'd0;
                        end else begin
                            bit_index_q <= 3'd0;
                            state       <= IDLE;
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    bit_index_q <= 3'd0;
                end
            endcase
        end
    end

endmodule
